bdiv: RTL and testbench

- Sequential fixed-point divider; the inverse companion of the bmul multiplier.
- Uses the same operand format as bmul: 8.8 unsigned operands, each split into integer and fraction bytes.
- Uses the same result format as bmul: 16.16 unsigned result split into four bytes.
- Uses the same in_rdy/res_rdy handshake as bmul.
- Computes a/b with radix-2 restoring division, one quotient bit per clock, so the datapath can recover a factor from a bmul product or normalise values.

---
 rtl/bdiv.sv | 116 +++++++++++
 tb/tb_bdiv.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bdiv.sv
// Sequential 8.8 / 8.8 unsigned fixed-point divider producing a 16.16 quotient.
// Radix-2 restoring division, one quotient bit per clock, bmul-style in_rdy/res_rdy handshake.
module bdiv #(
  parameter int ITER = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a_int,
  input  logic [7:0] a_dec,
  input  logic [7:0] b_int,
  input  logic [7:0] b_dec,
  input  logic       in_rdy,
  output logic [7:0] res_int1,
  output logic [7:0] res_int2,
  output logic [7:0] res_dec1,
  output logic [7:0] res_dec2,
  output logic       res_rdy,
  output logic       busy,
  output logic       div_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_reg;
  logic [15:0] b_reg;
  logic [31:0] n_reg;
  logic [16:0] r_reg;
  logic [31:0] q_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] res_reg;
  logic        res_rdy_reg;
  logic        busy_reg;
  logic        div_zero_reg;

  logic [15:0] b_in;
  logic [16:0] r_shift;
  logic        q_bit;
  logic [16:0] r_next;
  logic [31:0] q_next;

  assign b_in = {b_int, b_dec};

  // A set top remainder bit would mean the shifted value exceeds any 16-bit divisor.
  always_comb begin
    r_shift = {r_reg[15:0], n_reg[31]};
    q_bit   = r_reg[16] | (r_shift >= {1'b0, b_reg});
    r_next  = q_bit ? (r_shift - {1'b0, b_reg}) : r_shift;
    q_next  = {q_reg[30:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      b_reg        <= '0;
      n_reg        <= '0;
      r_reg        <= '0;
      q_reg        <= '0;
      cnt_reg      <= '0;
      res_reg      <= '0;
      res_rdy_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_rdy) begin
            busy_reg     <= 1'b1;
            div_zero_reg <= 1'b0;
            b_reg        <= b_in;
            n_reg        <= {a_int, a_dec, 16'h0000};
            r_reg        <= '0;
            q_reg        <= '0;
            cnt_reg      <= '0;
            if (b_in == 16'h0000) begin
              // Division by zero saturates and skips the iterations entirely.
              res_reg      <= 32'hFFFF_FFFF;
              div_zero_reg <= 1'b1;
              res_rdy_reg  <= 1'b1;
              state_reg    <= DONE;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          r_reg   <= r_next;
          n_reg   <= {n_reg[30:0], 1'b0};
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'(ITER - 1)) begin
            res_reg     <= q_next;
            res_rdy_reg <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          res_rdy_reg <= 1'b0;
          busy_reg    <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign res_int1 = res_reg[31:24];
  assign res_int2 = res_reg[23:16];
  assign res_dec1 = res_reg[15:8];
  assign res_dec2 = res_reg[7:0];
  assign res_rdy  = res_rdy_reg;
  assign busy     = busy_reg;
  assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_bdiv.sv
// Directed self-checking bench for bdiv: quotients, latency, divide-by-zero,
// ignored operands while busy, asynchronous abort and back-to-back re-triggering.
module tb_bdiv;

  logic       clk;
  logic       rst;
  logic [7:0] a_int, a_dec, b_int, b_dec;
  logic       in_rdy;
  logic [7:0] res_int1, res_int2, res_dec1, res_dec2;
  logic       res_rdy, busy, div_zero;

  int n_cmp;
  int n_bad;

  bdiv #(.ITER(32)) dut (
    .clk(clk), .rst(rst),
    .a_int(a_int), .a_dec(a_dec), .b_int(b_int), .b_dec(b_dec),
    .in_rdy(in_rdy),
    .res_int1(res_int1), .res_int2(res_int2), .res_dec1(res_dec1), .res_dec2(res_dec2),
    .res_rdy(res_rdy), .busy(busy), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dout();
    return {res_int1, res_int2, res_dec1, res_dec2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
    {a_int, a_dec} = a;
    {b_int, b_dec} = b;
  endtask

  // One-cycle in_rdy pulse; lat counts negedges after the accept edge until res_rdy.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_q, input logic exp_dz, input int exp_lat);
    int lat;
    @(negedge clk);
    set_ops(a, b);
    in_rdy = 1'b1;
    @(negedge clk);
    in_rdy = 1'b0;
    set_ops(16'hDEAD, 16'hBEEF);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!res_rdy && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".q"}, dout(), exp_q);
    chk({tag, ".dz"}, 32'(div_zero), 32'(exp_dz));
    @(negedge clk);
    chk({tag, ".rdy_off"}, 32'(res_rdy), 32'd0);
    chk({tag, ".busy_off"}, 32'(busy), 32'd0);
    chk({tag, ".q_hold"}, dout(), exp_q);
  endtask

  initial begin
    int pulses;
    int first_k;
    int prev_k;
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    in_rdy = 1'b0;
    set_ops(16'h0000, 16'h0000);

    #12;
    chk("rst.q", dout(), 32'h0);
    chk("rst.flags", {29'd0, res_rdy, busy, div_zero}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    run_div("d5_4",   16'h0500, 16'h0400, 32'h0001_4000, 1'b0, 33);
    run_div("d1_3",   16'h0100, 16'h0003, 32'h0055_5555, 1'b0, 33);
    run_div("dmax",   16'hFFFF, 16'h0001, 32'hFFFF_0000, 1'b0, 33);
    run_div("dzero",  16'h0000, 16'h1234, 32'h0000_0000, 1'b0, 33);
    run_div("div0",   16'h1234, 16'h0000, 32'hFFFF_FFFF, 1'b1, 1);
    run_div("clr_dz", 16'h0300, 16'h0100, 32'h0003_0000, 1'b0, 33);

    // Operands offered mid-calculation must be dropped.
    @(negedge clk);
    set_ops(16'h0500, 16'h0400);
    in_rdy = 1'b1;
    @(negedge clk);
    in_rdy = 1'b0;
    pulses = 0;
    first_k = 0;
    for (int k = 1; k <= 80; k++) begin
      if (k == 10) begin
        set_ops(16'h0100, 16'h0100);
        in_rdy = 1'b1;
      end else begin
        in_rdy = 1'b0;
      end
      if (res_rdy) begin
        pulses++;
        if (first_k == 0) first_k = k;
        chk("ign.q", dout(), 32'h0001_4000);
      end
      if (k == 34) chk("ign.busy_off", 32'(busy), 32'd0);
      @(negedge clk);
    end
    chk("ign.pulses", 32'(pulses), 32'd1);
    chk("ign.lat", 32'(first_k), 32'd33);

    // Asynchronous abort in the middle of a division.
    @(negedge clk);
    set_ops(16'h0700, 16'h0300);
    in_rdy = 1'b1;
    @(negedge clk);
    in_rdy = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort.q", dout(), 32'h0);
    chk("abort.flags", {29'd0, res_rdy, busy, div_zero}, 32'h0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b1;
      if (res_rdy) pulses++;
    end
    chk("abort.no_rdy", 32'(pulses), 32'd0);
    run_div("post_rst", 16'h0100, 16'h0200, 32'h0000_8000, 1'b0, 33);

    // in_rdy held high re-triggers on every IDLE cycle: one result per 34 cycles.
    @(negedge clk);
    set_ops(16'h0200, 16'h0100);
    in_rdy = 1'b1;
    pulses = 0;
    first_k = 0;
    prev_k = 0;
    for (int k = 0; k <= 80; k++) begin
      if (res_rdy) begin
        pulses++;
        chk("hold.q", dout(), 32'h0002_0000);
        if (first_k == 0) first_k = k;
        else chk("hold.period", 32'(k - prev_k), 32'd34);
        prev_k = k;
      end
      @(negedge clk);
    end
    in_rdy = 1'b0;
    chk("hold.first", 32'(first_k), 32'd33);
    chk("hold.pulses", 32'(pulses), 32'd2);
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
